ps2_keyboard_matrix: RTL and testbench
======================================

Name: ps2_keyboard_matrix

Overview:
Parametrised PS/2 keyboard-to-matrix emulator, the generalised successor of the fixed 8x8 keyboard block.
- Receives scan-code set 2 bytes from an internal ps2_intf instance.
- Tracks make/break, E0-extended and E1 (Pause) sequences with a prefix state machine.
- Maintains an active-low ROWS x COLS key matrix read by the CPU port through active-low row selects.
- Provides modifier outputs, a change-event pulse, and recovery on keyboard self-test or error codes.

Parameters:
ROWS, 8, number of matrix rows (1..16)
COLS, 8, number of matrix columns / data_o width (1..16)
PREFIX_TIMEOUT, 65535, clk cycles without a byte before a pending prefix is abandoned
RST_PULSE, 16, sys_rst_o pulse length in cycles (optional feature only)

Ports:
clk_i  in  1  system clock
rst_ni  in  1  asynchronous active-low reset
addr_i  in  ROWS  row select, active-low; several low bits allowed
data_o  out  COLS  column read, active-low (0 = pressed)
key_shft_o  out  1  shift state, active-low
key_ctrl_o  out  1  ctrl state, active-low
key_alt_o  out  1  alt state, active-low
key_event_o  out  1  one-cycle pulse on any matrix/modifier change
sys_rst_o  out  1  Ctrl+Alt+Del reset request, active-high
ps2_clk_i  in  1  PS/2 clock
ps2_data_i  in  1  PS/2 data

Behaviour:
- Clock and reset are fixed: one clock, clk_i; reset rst_ni is asynchronous and active-low. All state clears asynchronously while rst_ni=0.
- Reset values: every matrix bit is 1; key_shft_o, key_ctrl_o and key_alt_o are 1; key_event_o=0; sys_rst_o=0; FSM is in IDLE.
- Byte source: ps2_intf DATA/VALID, driven with nRESET=rst_ni. A VALID strobe lasts one cycle. Each valid byte is processed in exactly one cycle.
- FSM states: IDLE, BRK, EXT, EXT_BRK, SKIP.
  - IDLE: F0 -> BRK; E0 -> EXT; E1 -> SKIP with skip_cnt=7. Any other byte is a make code, then stay in IDLE.
  - BRK: any byte is a break code -> IDLE.
  - EXT: F0 -> EXT_BRK; any other byte is an extended make -> IDLE.
  - EXT_BRK: any byte is an extended break -> IDLE.
  - SKIP: each byte decrements skip_cnt. Return to IDLE when the count reaches 0. No matrix effect.
- Timeout: in any non-IDLE state, PREFIX_TIMEOUT cycles with no valid byte -> IDLE. The timeout counter reloads on every valid byte.
- Translation: {ext, code} goes through keymap_lookup to produce {hit, is_mod, mod_sel, row, col}.
  - Make writes 0; break writes 1.
  - A miss is ignored.
  - Extended codes E0 12 and E0 59 (fake shifts) are ignored.
  - E0 14 (right ctrl) maps to ctrl; E0 11 (right alt) maps to alt.
- Special bytes, decoded in IDLE only:
  - AA (self-test passed), FC (self-test fail), 00 or FF (overrun): all matrix bits and modifiers set to 1; FSM stays in IDLE.
  - FA (ack) and EE (echo): ignored.
- key_event_o pulses the cycle after the update, only if a stored bit actually changed. A repeated make (typematic) produces no pulse.
- Latency: the matrix and modifier registers update on the clock edge after VALID. data_o is combinational from the registers.
- Read path: data_o[c] = AND over rows r with addr_i[r]=0 of matrix[r][c]. All addr_i bits high -> all ones.
- A byte arriving on the same cycle as a timeout: the byte wins and is processed in the current state.

Optional Feature:
KBD_RESET_COMBO_EN
- Defined: a Delete make (71, or E0 71) while ctrl=0 and alt=0 raises sys_rst_o for RST_PULSE cycles. Retriggering during the pulse restarts the counter. The Delete key still updates the matrix normally if it is mapped.
- Undefined: sys_rst_o is tied to 0 and no pulse counter is built.

Decomposition:
- Package ps2_kbd_pkg holds:
  - FSM state enum.
  - Special byte constants (F0, E0, E1, AA, FC, FA, EE).
  - mod_sel encoding (SHFT/CTRL/ALT).
  - Default 8x8 map constants.
- One sub-module, keymap_lookup: purely combinational case table mapping {ext, code[7:0]} to hit/is_mod/mod_sel/row/col. The default contents are the existing 8x8 layout plus E0 arrow keys aliased to the plain arrow positions.

Test Plan:
- Reset, then addr_i=all ones and all single-zero selects -> data_o all ones; modifier outputs 1; key_event_o=0.
- Send 1C (A), then select row4 -> data_o=8'hFD with one key_event_o pulse. Send F0 1C -> data_o=8'hFF with a second pulse.
- Send E0 75 (extended Up), select row1 -> bit5 low. Send E0 12 -> no change and no pulse. Send E0 F0 75 -> bit5 high.
- Send E1 14 77 E1 F0 14 F0 77 (Pause), then 1C -> only row4 bit1 changes; Pause has no matrix effect.
- Send F0, wait PREFIX_TIMEOUT+1 cycles, send 16 -> row2 bit1 is pressed (make, not break). Hold 1C, send AA -> all ones.
- With KBD_RESET_COMBO_EN: send 14, 11, E0 71 -> sys_rst_o high for exactly 16 cycles. Without the macro, the same stimulus leaves sys_rst_o at 0.

Source files
------------

// File: rtl/ps2_kbd_pkg.sv
// Shared types and constants for the PS/2 keyboard-to-matrix emulator.
// Holds the prefix FSM state enum, special scan-code bytes, modifier select
// encoding, the default matrix geometry and the key-map result payload.
package ps2_kbd_pkg;

  localparam int unsigned IDX_W    = 4;   // row/col index width (up to 16x16)
  localparam int unsigned DEF_ROWS = 8;
  localparam int unsigned DEF_COLS = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BRK,
    ST_EXT,
    ST_EXT_BRK,
    ST_SKIP
  } kbd_state_e;

  typedef enum logic [1:0] {
    MOD_SHFT = 2'd0,
    MOD_CTRL = 2'd1,
    MOD_ALT  = 2'd2
  } mod_sel_e;

  localparam logic [7:0] CODE_BRK      = 8'hF0;
  localparam logic [7:0] CODE_EXT      = 8'hE0;
  localparam logic [7:0] CODE_PAUSE    = 8'hE1;
  localparam logic [7:0] CODE_BAT_OK   = 8'hAA;
  localparam logic [7:0] CODE_BAT_FAIL = 8'hFC;
  localparam logic [7:0] CODE_ACK      = 8'hFA;
  localparam logic [7:0] CODE_ECHO     = 8'hEE;
  localparam logic [7:0] CODE_OVR_LO   = 8'h00;
  localparam logic [7:0] CODE_OVR_HI   = 8'hFF;
  localparam logic [7:0] CODE_DEL      = 8'h71;

  // Bytes that follow E1 in the Pause sequence (14 77 E1 F0 14 F0 77)
  localparam logic [2:0] PAUSE_SKIP = 3'd7;

  typedef struct packed {
    logic             hit;
    logic             is_mod;
    mod_sel_e         mod_sel;
    logic [IDX_W-1:0] row;
    logic [IDX_W-1:0] col;
  } keymap_t;

  function automatic keymap_t key_at(input int unsigned r, input int unsigned c);
    keymap_t k;
    k.hit     = 1'b1;
    k.is_mod  = 1'b0;
    k.mod_sel = MOD_SHFT;
    k.row     = IDX_W'(r);
    k.col     = IDX_W'(c);
    return k;
  endfunction

  function automatic keymap_t mod_key(input mod_sel_e m);
    keymap_t k;
    k.hit     = 1'b1;
    k.is_mod  = 1'b1;
    k.mod_sel = m;
    k.row     = '0;
    k.col     = '0;
    return k;
  endfunction

endpackage

// File: rtl/keymap_lookup.sv
// Combinational scan-code set 2 to matrix position table.
// Ports: ext selects the E0 page, code is the scan byte, key returns
// {hit, is_mod, mod_sel, row, col}. E0 arrows and Delete alias the plain
// positions; E0 12 / E0 59 (fake shifts) are deliberately absent.
module keymap_lookup
  import ps2_kbd_pkg::*;
(
  input  logic       ext,
  input  logic [7:0] code,
  output keymap_t    key
);

  always_comb begin
    key = '0;
    if (ext) begin
      case (code)
        8'h6B:   key = key_at(1, 3);
        8'h74:   key = key_at(1, 4);
        8'h75:   key = key_at(1, 5);
        8'h72:   key = key_at(1, 6);
        8'h71:   key = key_at(1, 7);
        8'h14:   key = mod_key(MOD_CTRL);
        8'h11:   key = mod_key(MOD_ALT);
        default: key = '0;
      endcase
    end else begin
      case (code)
        8'h76: key = key_at(0, 0);  8'h05: key = key_at(0, 1);
        8'h06: key = key_at(0, 2);  8'h04: key = key_at(0, 3);
        8'h0C: key = key_at(0, 4);  8'h66: key = key_at(0, 5);
        8'h5A: key = key_at(0, 6);  8'h29: key = key_at(0, 7);
        8'h0E: key = key_at(1, 0);  8'h0D: key = key_at(1, 1);
        8'h58: key = key_at(1, 2);  8'h6B: key = key_at(1, 3);
        8'h74: key = key_at(1, 4);  8'h75: key = key_at(1, 5);
        8'h72: key = key_at(1, 6);  8'h71: key = key_at(1, 7);
        8'h45: key = key_at(2, 0);  8'h16: key = key_at(2, 1);
        8'h1E: key = key_at(2, 2);  8'h26: key = key_at(2, 3);
        8'h25: key = key_at(2, 4);  8'h2E: key = key_at(2, 5);
        8'h36: key = key_at(2, 6);  8'h3D: key = key_at(2, 7);
        8'h3E: key = key_at(3, 0);  8'h46: key = key_at(3, 1);
        8'h4E: key = key_at(3, 2);  8'h55: key = key_at(3, 3);
        8'h15: key = key_at(3, 4);  8'h1D: key = key_at(3, 5);
        8'h24: key = key_at(3, 6);  8'h2D: key = key_at(3, 7);
        8'h2C: key = key_at(4, 0);  8'h1C: key = key_at(4, 1);
        8'h1B: key = key_at(4, 2);  8'h23: key = key_at(4, 3);
        8'h2B: key = key_at(4, 4);  8'h34: key = key_at(4, 5);
        8'h33: key = key_at(4, 6);  8'h3B: key = key_at(4, 7);
        8'h42: key = key_at(5, 0);  8'h4B: key = key_at(5, 1);
        8'h4C: key = key_at(5, 2);  8'h52: key = key_at(5, 3);
        8'h1A: key = key_at(5, 4);  8'h22: key = key_at(5, 5);
        8'h21: key = key_at(5, 6);  8'h2A: key = key_at(5, 7);
        8'h32: key = key_at(6, 0);  8'h31: key = key_at(6, 1);
        8'h3A: key = key_at(6, 2);  8'h41: key = key_at(6, 3);
        8'h49: key = key_at(6, 4);  8'h4A: key = key_at(6, 5);
        8'h35: key = key_at(6, 6);  8'h3C: key = key_at(6, 7);
        8'h43: key = key_at(7, 0);  8'h44: key = key_at(7, 1);
        8'h4D: key = key_at(7, 2);  8'h54: key = key_at(7, 3);
        8'h5B: key = key_at(7, 4);  8'h5D: key = key_at(7, 5);
        8'h0B: key = key_at(7, 6);  8'h83: key = key_at(7, 7);
        8'h12: key = mod_key(MOD_SHFT);
        8'h59: key = mod_key(MOD_SHFT);
        8'h14: key = mod_key(MOD_CTRL);
        8'h11: key = mod_key(MOD_ALT);
        default: key = '0;
      endcase
    end
  end

endmodule

// File: rtl/ps2_intf.sv
// PS/2 device-to-host byte receiver.
// Ports: CLK system clock, nRESET async active-low reset, PS2_CLK/PS2_DATA
// raw PS/2 lines, DATA received byte, VALID one-cycle strobe for a frame
// with correct start, odd parity and stop bits.
module ps2_intf (
  input  logic       CLK,
  input  logic       nRESET,
  input  logic       PS2_CLK,
  input  logic       PS2_DATA,
  output logic [7:0] DATA,
  output logic       VALID
);

  logic [2:0] clk_sync;
  logic [1:0] dat_sync;
  logic [9:0] shift;
  logic [3:0] bit_cnt;
  logic       clk_fall;

  assign clk_fall = clk_sync[2] & ~clk_sync[1];

  // Bits arrive LSB first; after ten shifts shift[0] is the start bit
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      clk_sync <= '1;
      dat_sync <= '1;
      shift    <= '0;
      bit_cnt  <= '0;
      DATA     <= '0;
      VALID    <= 1'b0;
    end else begin
      clk_sync <= {clk_sync[1:0], PS2_CLK};
      dat_sync <= {dat_sync[0], PS2_DATA};
      VALID    <= 1'b0;
      if (clk_fall) begin
        if (bit_cnt == 4'd10) begin
          bit_cnt <= '0;
          if (!shift[0] && dat_sync[1] && (^shift[9:1])) begin
            DATA  <= shift[8:1];
            VALID <= 1'b1;
          end
        end else begin
          shift   <= {dat_sync[1], shift[9:1]};
          bit_cnt <= bit_cnt + 4'd1;
        end
      end
    end
  end

endmodule

// File: rtl/ps2_keyboard_matrix.sv
// PS/2 keyboard to active-low ROWS x COLS key matrix emulator.
// Ports: clk_i, rst_ni (async active-low); addr_i active-low row selects;
// data_o active-low column read (AND of selected rows); key_shft_o,
// key_ctrl_o, key_alt_o active-low modifiers; key_event_o one-cycle change
// pulse; sys_rst_o Ctrl+Alt+Del request; ps2_clk_i/ps2_data_i PS/2 lines.
// Optional macro KBD_RESET_COMBO_EN builds the Ctrl+Alt+Del pulse generator;
// without it sys_rst_o is tied low.
module ps2_keyboard_matrix
  import ps2_kbd_pkg::*;
#(
  parameter int unsigned ROWS           = DEF_ROWS,
  parameter int unsigned COLS           = DEF_COLS,
  parameter int unsigned PREFIX_TIMEOUT = 65535,
  parameter int unsigned RST_PULSE      = 16
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [ROWS-1:0] addr_i,
  output logic [COLS-1:0] data_o,
  output logic            key_shft_o,
  output logic            key_ctrl_o,
  output logic            key_alt_o,
  output logic            key_event_o,
  output logic            sys_rst_o,
  input  logic            ps2_clk_i,
  input  logic            ps2_data_i
);

  localparam int unsigned TMO_W = $clog2(PREFIX_TIMEOUT + 1);

  logic [7:0]                 ps2_byte;
  logic                       ps2_valid;
  kbd_state_e                 state_q, state_d;
  logic [2:0]                 skip_q, skip_d;
  logic [TMO_W-1:0]           tmo_q, tmo_d;
  logic [ROWS-1:0][COLS-1:0]  matrix_q, matrix_d;
  logic                       shft_q, shft_d, ctrl_q, ctrl_d, alt_q, alt_d;
  logic                       event_q, event_d;
  logic                       lookup_ext;
  keymap_t                    key_c;
  logic                       key_apply, key_make, clear_all;

  ps2_intf u_ps2_intf (
    .CLK      (clk_i),
    .nRESET   (rst_ni),
    .PS2_CLK  (ps2_clk_i),
    .PS2_DATA (ps2_data_i),
    .DATA     (ps2_byte),
    .VALID    (ps2_valid)
  );

  assign lookup_ext = (state_q == ST_EXT) || (state_q == ST_EXT_BRK);

  keymap_lookup u_keymap_lookup (
    .ext  (lookup_ext),
    .code (ps2_byte),
    .key  (key_c)
  );

  // Prefix FSM, timeout and matrix/modifier next state
  always_comb begin
    state_d   = state_q;
    skip_d    = skip_q;
    matrix_d  = matrix_q;
    shft_d    = shft_q;
    ctrl_d    = ctrl_q;
    alt_d     = alt_q;
    key_apply = 1'b0;
    key_make  = 1'b0;
    clear_all = 1'b0;
    tmo_d     = (ps2_valid || state_q == ST_IDLE) ? '0 : tmo_q + TMO_W'(1);

    if (ps2_valid) begin
      case (state_q)
        ST_IDLE: begin
          if (ps2_byte == CODE_BRK) begin
            state_d = ST_BRK;
          end else if (ps2_byte == CODE_EXT) begin
            state_d = ST_EXT;
          end else if (ps2_byte == CODE_PAUSE) begin
            state_d = ST_SKIP;
            skip_d  = PAUSE_SKIP;
          end else if (ps2_byte == CODE_BAT_OK || ps2_byte == CODE_BAT_FAIL ||
                       ps2_byte == CODE_OVR_LO || ps2_byte == CODE_OVR_HI) begin
            clear_all = 1'b1;
          end else if (ps2_byte != CODE_ACK && ps2_byte != CODE_ECHO) begin
            key_apply = 1'b1;
            key_make  = 1'b1;
          end
        end
        ST_BRK: begin
          key_apply = 1'b1;
          state_d   = ST_IDLE;
        end
        ST_EXT: begin
          if (ps2_byte == CODE_BRK) begin
            state_d = ST_EXT_BRK;
          end else begin
            key_apply = 1'b1;
            key_make  = 1'b1;
            state_d   = ST_IDLE;
          end
        end
        ST_EXT_BRK: begin
          key_apply = 1'b1;
          state_d   = ST_IDLE;
        end
        ST_SKIP: begin
          skip_d = skip_q - 3'd1;
          if (skip_q == 3'd1) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (state_q != ST_IDLE && tmo_q == TMO_W'(PREFIX_TIMEOUT - 1)) begin
      state_d = ST_IDLE;
    end

    // Make drives the stored bit low, break drives it high
    if (key_apply && key_c.hit) begin
      if (key_c.is_mod) begin
        case (key_c.mod_sel)
          MOD_SHFT: shft_d = ~key_make;
          MOD_CTRL: ctrl_d = ~key_make;
          MOD_ALT:  alt_d  = ~key_make;
          default:  ;
        endcase
      end else begin
        for (int r = 0; r < ROWS; r++) begin
          for (int c = 0; c < COLS; c++) begin
            if (key_c.row == IDX_W'(r) && key_c.col == IDX_W'(c)) begin
              matrix_d[r][c] = ~key_make;
            end
          end
        end
      end
    end

    if (clear_all) begin
      matrix_d = '1;
      shft_d   = 1'b1;
      ctrl_d   = 1'b1;
      alt_d    = 1'b1;
    end

    event_d = (matrix_d != matrix_q) ||
              ({shft_d, ctrl_d, alt_d} != {shft_q, ctrl_q, alt_q});
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      skip_q   <= '0;
      tmo_q    <= '0;
      matrix_q <= '1;
      shft_q   <= 1'b1;
      ctrl_q   <= 1'b1;
      alt_q    <= 1'b1;
      event_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      skip_q   <= skip_d;
      tmo_q    <= tmo_d;
      matrix_q <= matrix_d;
      shft_q   <= shft_d;
      ctrl_q   <= ctrl_d;
      alt_q    <= alt_d;
      event_q  <= event_d;
    end
  end

  assign key_shft_o  = shft_q;
  assign key_ctrl_o  = ctrl_q;
  assign key_alt_o   = alt_q;
  assign key_event_o = event_q;

  // Column read: AND of every selected (low) row
  always_comb begin
    data_o = '1;
    for (int r = 0; r < ROWS; r++) begin
      if (!addr_i[r]) data_o = data_o & matrix_q[r];
    end
  end

`ifdef KBD_RESET_COMBO_EN
  localparam int unsigned RCNT_W = (RST_PULSE > 1) ? $clog2(RST_PULSE) : 1;

  logic [RCNT_W-1:0] rst_cnt_q;
  logic              sys_rst_q;
  logic              combo_c;

  // Delete make with both ctrl and alt already held
  assign combo_c = key_apply && key_make && (ps2_byte == CODE_DEL) && !ctrl_q && !alt_q;

  // Pulse of RST_PULSE cycles; a retrigger reloads the counter
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rst_cnt_q <= '0;
      sys_rst_q <= 1'b0;
    end else if (combo_c) begin
      rst_cnt_q <= RCNT_W'(RST_PULSE - 1);
      sys_rst_q <= 1'b1;
    end else if (rst_cnt_q != '0) begin
      rst_cnt_q <= rst_cnt_q - RCNT_W'(1);
    end else begin
      sys_rst_q <= 1'b0;
    end
  end

  assign sys_rst_o = sys_rst_q;
`else
  logic unused_rst_pulse;
  assign unused_rst_pulse = (RST_PULSE == 0);
  assign sys_rst_o        = 1'b0;
`endif

endmodule

// File: tb/tb_ps2_keyboard_matrix.sv
// Scoreboard bench for ps2_keyboard_matrix: stimulus pushes the expected
// matrix/modifier snapshot for every change it causes; the monitor pops one
// entry per key_event_o pulse and reads the whole matrix back via addr_i.
module tb_ps2_keyboard_matrix;

  localparam int ROWS = 8;
  localparam int COLS = 8;
  localparam int PT   = 1000;
  localparam int RP   = 16;
  localparam int HALF = 8;

  typedef struct packed {
    logic [7:0][7:0] mat;
    logic [2:0]      mods;   // {shft, ctrl, alt}
  } exp_t;

  logic            clk      = 1'b0;
  logic            rst_n    = 1'b0;
  logic [ROWS-1:0] addr     = '1;
  logic [COLS-1:0] data;
  logic            k_shft, k_ctrl, k_alt, k_event, sys_rst;
  logic            ps2_clk  = 1'b1;
  logic            ps2_data = 1'b1;

  exp_t            exp_q[$];
  logic [7:0][7:0] exp_mat  = '1;
  logic [2:0]      exp_mods = 3'b111;
  int              total = 0;
  int              bad   = 0;
  int              events_seen = 0;
  int              rst_hi_cycles = 0;
  bit              mon_ready = 1'b0;
  bit              stim_done = 1'b0;
  bit              drain_timeout = 1'b0;

  always #5 clk = ~clk;

  ps2_keyboard_matrix #(
    .ROWS(ROWS), .COLS(COLS), .PREFIX_TIMEOUT(PT), .RST_PULSE(RP)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .addr_i      (addr),
    .data_o      (data),
    .key_shft_o  (k_shft),
    .key_ctrl_o  (k_ctrl),
    .key_alt_o   (k_alt),
    .key_event_o (k_event),
    .sys_rst_o   (sys_rst),
    .ps2_clk_i   (ps2_clk),
    .ps2_data_i  (ps2_data)
  );

  always @(negedge clk) if (sys_rst) rst_hi_cycles <= rst_hi_cycles + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_exp();
    exp_t e;
    e.mat  = exp_mat;
    e.mods = exp_mods;
    exp_q.push_back(e);
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic [10:0] fr;
    fr = {1'b1, ~^b, b, 1'b0};
    for (int i = 0; i < 11; i++) begin
      @(negedge clk) ps2_data = fr[i];
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    repeat (4 * HALF) @(negedge clk);
  endtask

  task automatic send_seq(input logic [7:0] s [], input int n);
    for (int i = 0; i < n; i++) send_byte(s[i]);
  endtask

  // Stimulus
  initial begin
    logic [7:0] pause_seq [];
    pause_seq = new[8];
    pause_seq[0] = 8'hE1; pause_seq[1] = 8'h14; pause_seq[2] = 8'h77; pause_seq[3] = 8'hE1;
    pause_seq[4] = 8'hF0; pause_seq[5] = 8'h14; pause_seq[6] = 8'hF0; pause_seq[7] = 8'h77;

    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 100 && !mon_ready; n++) @(negedge clk);

    // A make then break
    exp_mat[4][1] = 1'b0; push_exp();
    send_byte(8'h1C);
    exp_mat[4][1] = 1'b1; push_exp();
    send_byte(8'hF0); send_byte(8'h1C);

    // Extended Up make, fake shift, extended break
    exp_mat[1][5] = 1'b0; push_exp();
    send_byte(8'hE0); send_byte(8'h75);
    send_byte(8'hE0); send_byte(8'h12);
    exp_mat[1][5] = 1'b1; push_exp();
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);

    // Pause has no effect; next A make lands normally
    send_seq(pause_seq, 8);
    exp_mat[4][1] = 1'b0; push_exp();
    send_byte(8'h1C);

    // Abandoned F0 prefix: following 16 is a make
    send_byte(8'hF0);
    repeat (PT + 1) @(negedge clk);
    exp_mat[2][1] = 1'b0; push_exp();
    send_byte(8'h16);

    // Typematic repeat, then self-test clears everything
    send_byte(8'h1C);
    exp_mat = '1; push_exp();
    send_byte(8'hAA);
    send_byte(8'hFA); send_byte(8'hEE);

    // Ctrl + Alt + E0 Delete
    exp_mods = 3'b101; push_exp();
    send_byte(8'h14);
    exp_mods = 3'b100; push_exp();
    send_byte(8'h11);
    exp_mat[1][7] = 1'b0; push_exp();
    send_byte(8'hE0); send_byte(8'h71);
    repeat (60) @(negedge clk);

    // Overrun clears matrix and modifiers
    exp_mat = '1; exp_mods = 3'b111; push_exp();
    send_byte(8'hFF);

    for (int n = 0; n < 500 && exp_q.size() != 0; n++) @(negedge clk);
    drain_timeout = (exp_q.size() != 0);
    stim_done = 1'b1;
  end

  // Monitor / scoreboard
  initial begin
    exp_t            e;
    logic [7:0][7:0] act;
    logic [7:0]      all_rows, and_exp;

    @(posedge rst_n);
    @(negedge clk);
    addr = '1; #1;
    chk("rst_no_select", 64'(data), 64'hFF);
    for (int r = 0; r < ROWS; r++) begin
      addr = ~(8'(1) << r); #1;
      chk($sformatf("rst_row%0d", r), 64'(data), 64'hFF);
    end
    addr = '1;
    chk("rst_mods", 64'({k_shft, k_ctrl, k_alt}), 64'h7);
    chk("rst_event", 64'(k_event), 64'h0);
    chk("rst_sys_rst", 64'(sys_rst), 64'h0);
    mon_ready = 1'b1;

    while (!stim_done) begin
      @(negedge clk);
      if (k_event) begin
        events_seen++;
        for (int r = 0; r < ROWS; r++) begin
          addr = ~(8'(1) << r); #1;
          act[r] = data;
        end
        addr = '0; #1;
        all_rows = data;
        addr = '1;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_event: got matrix %h with empty queue", act);
        end else begin
          e = exp_q.pop_front();
          chk("event_matrix", 64'(act), 64'(e.mat));
          chk("event_mods", 64'({k_shft, k_ctrl, k_alt}), 64'(e.mods));
          and_exp = '1;
          for (int r = 0; r < ROWS; r++) and_exp = and_exp & e.mat[r];
          chk("event_all_rows", 64'(all_rows), 64'(and_exp));
        end
      end
    end

    chk("drain_timeout", 64'(drain_timeout), 64'h0);
    chk("pending_expected", 64'(exp_q.size()), 64'h0);
    chk("event_count", 64'(events_seen), 64'd11);
`ifdef KBD_RESET_COMBO_EN
    chk("sys_rst_cycles", 64'(rst_hi_cycles), 64'(RP));
`else
    chk("sys_rst_cycles", 64'(rst_hi_cycles), 64'h0);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got no completion expected finish within 2ms");
    $fatal(1, "watchdog");
  end

endmodule
